// File: rtl/pulse_cnt_pkg.sv
// Shared definitions for the multi-channel pulse/event counter.
//   CNT_MODE_LEVEL / CNT_MODE_EDGE : values of a channel's edge_mode bit
//   CNT_WRAP / CNT_SAT             : values of a channel's sat_mode bit
//   ch_lo()                        : LSB index of channel k in a packed bus
package pulse_cnt_pkg;

    localparam logic CNT_MODE_LEVEL = 1'b0;
    localparam logic CNT_MODE_EDGE  = 1'b1;

    localparam logic CNT_WRAP = 1'b0;
    localparam logic CNT_SAT  = 1'b1;

    // Channel k occupies [ch_lo(k, w) +: w] of every packed per-channel bus.
    function automatic int ch_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/pulse_cnt_ch.sv
// One counter channel: edge detect, wrap/saturate counter, window snapshot
// register and sticky overflow flag.
//   clk, rst_n    : clock, asynchronous active-low reset
//   clc_i         : synchronous clear of count, snapshot and overflow flag
//   win_end_i     : shared window end; snapshot next count and restart at 0
//   d_i           : event input
//   edge_mode_i   : CNT_MODE_EDGE counts rising edges, else high cycles
//   sat_mode_i    : CNT_SAT holds at all-ones, else wraps to 0
//   cnt_o         : running count
//   snap_o        : count captured at the last window end
//   ovf_o         : sticky overflow/saturation flag
module pulse_cnt_ch
    import pulse_cnt_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clc_i,
    input  logic                 win_end_i,
    input  logic                 d_i,
    input  logic                 edge_mode_i,
    input  logic                 sat_mode_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic [CNT_WIDTH-1:0] snap_o,
    output logic                 ovf_o
);

    logic                 prev_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] snap_q, snap_d;
    logic                 ovf_q, ovf_d;

    logic                 inc;
    logic                 ovf_hit;
    logic [CNT_WIDTH-1:0] next_cnt;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        inc      = (edge_mode_i == CNT_MODE_EDGE) ? (d_i & ~prev_q) : d_i;
        ovf_hit  = inc & (&cnt_q);
        next_cnt = cnt_q + CNT_WIDTH'(inc);
        if (ovf_hit) begin
            next_cnt = (sat_mode_i == CNT_SAT) ? cnt_q : '0;
        end

        cnt_d  = next_cnt;
        snap_d = snap_q;
        ovf_d  = ovf_q | ovf_hit;
        if (clc_i) begin
            // The event sampled in a clear cycle is intentionally dropped.
            cnt_d  = '0;
            snap_d = '0;
            ovf_d  = 1'b0;
        end else if (win_end_i) begin
            // Snapshot includes this cycle's event; overflow still latches.
            snap_d = next_cnt;
            cnt_d  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
            snap_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            // Edge history tracks the input every cycle; clc does not touch it.
            prev_q <= d_i;
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign snap_o = snap_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/pulse_cnt_mc.sv
// Multi-channel pulse/event counter with a shared measurement window that
// periodically snapshots and clears all running counts.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clc         : synchronous clear of counts, snapshots, flags, window counter
//   d_i         : per-channel event inputs
//   edge_mode_i : per-channel edge (1) / level (0) counting
//   sat_mode_i  : per-channel saturate (1) / wrap (0)
//   win_len_i   : window length in cycles, 0 disables windowing
//   cnt_o       : running counts, channel k at [k*CNT_WIDTH +: CNT_WIDTH]
//   snap_o      : last window snapshot, same packing
//   snap_vld_o  : one-cycle pulse when snap_o updates
//   ovf_o       : sticky per-channel overflow flags
module pulse_cnt_mc
    import pulse_cnt_pkg::*;
#(
    parameter int unsigned CH_NUM    = 4,
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned WIN_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clc,
    input  logic [CH_NUM-1:0]           d_i,
    input  logic [CH_NUM-1:0]           edge_mode_i,
    input  logic [CH_NUM-1:0]           sat_mode_i,
    input  logic [WIN_WIDTH-1:0]        win_len_i,
    output logic [CH_NUM*CNT_WIDTH-1:0] cnt_o,
    output logic [CH_NUM*CNT_WIDTH-1:0] snap_o,
    output logic                        snap_vld_o,
    output logic [CH_NUM-1:0]           ovf_o
);

    logic [WIN_WIDTH-1:0] win_cnt_q, win_cnt_d;
    logic                 snap_vld_q;
    logic                 win_en;
    logic                 win_end;

    // ">=" rather than "==" so a window shortened below the current count
    // terminates on the next cycle instead of running until wrap-around.
    assign win_en  = (win_len_i != '0);
    assign win_end = win_en && (win_cnt_q >= (win_len_i - WIN_WIDTH'(1)));

    always_comb begin
        win_cnt_d = win_cnt_q + WIN_WIDTH'(1);
        if (clc || !win_en || win_end) begin
            win_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q  <= '0;
            snap_vld_q <= 1'b0;
        end else begin
            win_cnt_q  <= win_cnt_d;
            snap_vld_q <= win_end & ~clc;
        end
    end

    assign snap_vld_o = snap_vld_q;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        pulse_cnt_ch #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .clc_i      (clc),
            .win_end_i  (win_end),
            .d_i        (d_i[k]),
            .edge_mode_i(edge_mode_i[k]),
            .sat_mode_i (sat_mode_i[k]),
            .cnt_o      (cnt_o[ch_lo(k, CNT_WIDTH) +: CNT_WIDTH]),
            .snap_o     (snap_o[ch_lo(k, CNT_WIDTH) +: CNT_WIDTH]),
            .ovf_o      (ovf_o[k])
        );
    end

endmodule
